collision_scheduler: RTL
========================

Name: collision_scheduler

Overview:
- Time-multiplexes one combinational bounding-box collision checker (player car 16x32 vs one enemy car) across up to NUM_CARS enemy cars, once per video frame.
- Snapshots all positions on frame_start, then steps an index through the enemies, driving the checker operands and collecting one result per active enemy.
- Publishes a per-car hit mask, an any-crash flag and the lowest hit index to the game-logic FSM.
- Sits between the frame timing generator, the car position registers and the single shared checker instance.

Parameters:
- NUM_CARS, 8, number of enemy car slots scanned per frame.
- IDX_W, 3, index width; must satisfy 2**IDX_W >= NUM_CARS.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- frame_start  input  1  one-cycle pulse requesting a scan.
- player_x  input  8  player car left edge.
- player_y  input  10  player car top edge.
- enemy_x  input  NUM_CARS*8  enemy left edges; slot i in bits [8i+7:8i].
- enemy_y  input  NUM_CARS*10  enemy top edges; slot i in bits [10i+9:10i].
- enemy_active  input  NUM_CARS  slot-valid flags.
- chk_pos1_x  output  8  checker operand 1 x (player).
- chk_pos1_y  output  10  checker operand 1 y.
- chk_pos2_x  output  8  checker operand 2 x (enemy).
- chk_pos2_y  output  10  checker operand 2 y.
- chk_colision  input  1  checker result, combinational from chk_pos*.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; results valid.
- hit_mask  output  NUM_CARS  bit i set when enemy i collided in the last completed scan.
- crash  output  1  OR of hit_mask.
- crash_idx  output  IDX_W  lowest set index of hit_mask; 0 when hit_mask is 0.
- overrun  output  1  sticky: frame_start arrived while busy.

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs, snapshot registers, index and scratch mask go to 0. An in-flight scan is aborted and no done is produced.
- All outputs are registered. chk_pos* come from operand registers.
- IDLE: when frame_start=1, snapshot player_x/y, enemy_x/y and enemy_active; set idx=0 and scratch=0; go to LOAD. Position changes after the snapshot do not affect the scan.
- LOAD:
  - If active_snap[idx]=1: chk_pos1 <= player snapshot, chk_pos2 <= enemy[idx] snapshot; go to CHECK.
  - If active_snap[idx]=0: scratch[idx] stays 0, operands hold. Go to DONE if idx=NUM_CARS-1, otherwise idx++ and stay in LOAD.
- CHECK: operands are stable. Set scratch[idx] <= chk_colision. Go to DONE if idx=NUM_CARS-1, otherwise idx++ and go to LOAD. idx never wraps.
- DONE: at exit, hit_mask <= scratch, crash <= |scratch, crash_idx <= priority encode of scratch (lowest index), done <= 1; go to IDLE. done drops the next cycle.
- Results hold between scans.
- Latency: cost = sum over slots of (2 if active, else 1). With frame_start sampled in cycle 0, done is high in cycle cost+2.
  - All 8 active: done in cycle 18.
  - None active: done in cycle 10.
- frame_start in the same cycle as done (state IDLE) is accepted.
- frame_start in any non-IDLE state is ignored and sets overrun=1. overrun clears only on reset.
- Width rules: the checker owns all bound arithmetic. This block only moves operands and does no arithmetic apart from idx.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> busy, done, hit_mask, crash, crash_idx, overrun and chk_pos* are all 0.
- NUM_CARS=8, all active, player (100,200), enemy3 (104,210), others (0,0), frame_start at cycle 0 -> done only in cycle 18, hit_mask=8'h08, crash=1, crash_idx=3, busy high cycles 1-17.
- enemy_active=0 -> done in cycle 10, hit_mask=0, crash=0, crash_idx=0, chk_pos* unchanged from reset.
- Enemies 2 and 5 overlap the player; move enemy 2 away at cycle 3 mid-scan -> hit_mask=8'h24, crash_idx=2 (snapshot used).
- Second frame_start at cycle 7 of a scan -> overrun=1, exactly one done (cycle 18), no new scan until the next frame_start. Then frame_start in the done cycle -> a new scan starts.
- reset_n low at cycle 5 of a scan -> outputs 0 immediately, no done. After release, frame_start -> normal scan and results.

Source files
------------

// File: rtl/collision_scheduler.sv
// Collision scheduler: shares one combinational bounding-box checker across
// NUM_CARS enemy slots. Positions are snapshotted on frame_start, each active
// slot gets a LOAD (drive operands) and a CHECK (sample result) cycle, and the
// per-slot results are published together in the DONE state.
module collision_scheduler #(
  parameter int unsigned NUM_CARS = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic [7:0]             player_x,
  input  logic [9:0]             player_y,
  input  logic [NUM_CARS*8-1:0]  enemy_x,
  input  logic [NUM_CARS*10-1:0] enemy_y,
  input  logic [NUM_CARS-1:0]    enemy_active,
  output logic [7:0]             chk_pos1_x,
  output logic [9:0]             chk_pos1_y,
  output logic [7:0]             chk_pos2_x,
  output logic [9:0]             chk_pos2_y,
  input  logic                   chk_colision,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_CARS-1:0]    hit_mask,
  output logic                   crash,
  output logic [IDX_W-1:0]       crash_idx,
  output logic                   overrun
);

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_CARS-1:0]    scratch_q, scratch_d;
  logic [7:0]             px_q, px_d;
  logic [9:0]             py_q, py_d;
  logic [NUM_CARS*8-1:0]  ex_q, ex_d;
  logic [NUM_CARS*10-1:0] ey_q, ey_d;
  logic [NUM_CARS-1:0]    act_q, act_d;
  logic [7:0]             c1x_q, c1x_d, c2x_q, c2x_d;
  logic [9:0]             c1y_q, c1y_d, c2y_q, c2y_d;
  logic [NUM_CARS-1:0]    hit_q, hit_d;
  logic                   crash_q, crash_d;
  logic [IDX_W-1:0]       cidx_q, cidx_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;
  logic [IDX_W-1:0]       enc;
  logic                   last;

  assign last = (idx_q == IDX_W'(NUM_CARS - 1));

  // Lowest-index priority encoder over the scratch mask.
  always_comb begin
    enc = '0;
    for (int i = int'(NUM_CARS) - 1; i >= 0; i--) begin
      if (scratch_q[i]) enc = IDX_W'(i);
    end
  end

  // Next-state logic for the scan FSM, operands and published results.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    scratch_d = scratch_q;
    px_d      = px_q;
    py_d      = py_q;
    ex_d      = ex_q;
    ey_d      = ey_q;
    act_d     = act_q;
    c1x_d     = c1x_q;
    c1y_d     = c1y_q;
    c2x_d     = c2x_q;
    c2y_d     = c2y_q;
    hit_d     = hit_q;
    crash_d   = crash_q;
    cidx_d    = cidx_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q;

    // A request while a scan is in flight is dropped but remembered.
    if (frame_start && (state_q != StIdle)) ovr_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          px_d      = player_x;
          py_d      = player_y;
          ex_d      = enemy_x;
          ey_d      = enemy_y;
          act_d     = enemy_active;
          idx_d     = '0;
          scratch_d = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (act_q[idx_q]) begin
          c1x_d   = px_q;
          c1y_d   = py_q;
          c2x_d   = ex_q[int'(idx_q)*8 +: 8];
          c2y_d   = ey_q[int'(idx_q)*10 +: 10];
          state_d = StCheck;
        end else if (last) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StCheck: begin
        // Operands were registered last cycle, so the checker output is settled.
        scratch_d[idx_q] = chk_colision;
        if (last) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StLoad;
        end
      end
      StDone: begin
        hit_d   = scratch_q;
        crash_d = |scratch_q;
        cidx_d  = enc;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset aborts any scan in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      scratch_q <= '0;
      px_q      <= '0;
      py_q      <= '0;
      ex_q      <= '0;
      ey_q      <= '0;
      act_q     <= '0;
      c1x_q     <= '0;
      c1y_q     <= '0;
      c2x_q     <= '0;
      c2y_q     <= '0;
      hit_q     <= '0;
      crash_q   <= 1'b0;
      cidx_q    <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      scratch_q <= scratch_d;
      px_q      <= px_d;
      py_q      <= py_d;
      ex_q      <= ex_d;
      ey_q      <= ey_d;
      act_q     <= act_d;
      c1x_q     <= c1x_d;
      c1y_q     <= c1y_d;
      c2x_q     <= c2x_d;
      c2y_q     <= c2y_d;
      hit_q     <= hit_d;
      crash_q   <= crash_d;
      cidx_q    <= cidx_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign chk_pos1_x = c1x_q;
  assign chk_pos1_y = c1y_q;
  assign chk_pos2_x = c2x_q;
  assign chk_pos2_y = c2y_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign hit_mask   = hit_q;
  assign crash      = crash_q;
  assign crash_idx  = cidx_q;
  assign overrun    = ovr_q;

endmodule
